// File: rtl/timed_event_dispatcher.sv
// Timestamped event queue: a small FIFO feeding a head register that fires
// its payload when the rtio counter matches, or drops it when already late.
module timed_event_dispatcher #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_ADDR  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [63:0]           counter,
    input  logic                  auto_start,
    input  logic                  event_valid,
    output logic                  event_ready,
    input  logic [63:0]           event_time,
    input  logic [DATA_WIDTH-1:0] event_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  underflow,
    output logic [15:0]           dropped_count,
    input  logic                  clear_flags,
    output logic                  queue_empty
);

    localparam logic [FIFO_ADDR:0] PTR_ONE = 1;

    logic [63:0]           mem_time [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_ADDR:0]    wr_ptr;
    logic [FIFO_ADDR:0]    rd_ptr;

    logic                  head_valid;
    logic [63:0]           head_time;
    logic [DATA_WIDTH-1:0] head_data;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic cmp_en;
    logic fire;
    logic drop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FIFO_ADDR] != rd_ptr[FIFO_ADDR]) &&
                        (wr_ptr[FIFO_ADDR-1:0] == rd_ptr[FIFO_ADDR-1:0]);

    assign event_ready = !fifo_full;
    assign push        = event_valid && !fifo_full;

    assign cmp_en = head_valid && auto_start;
    assign fire   = cmp_en && (counter == head_time);
    assign drop   = cmp_en && (counter > head_time);
    assign pop    = !fifo_empty && (!head_valid || fire || drop);

    assign queue_empty = fifo_empty && !head_valid;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_time[wr_ptr[FIFO_ADDR-1:0]] <= event_time;
            mem_data[wr_ptr[FIFO_ADDR-1:0]] <= event_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            head_valid    <= 1'b0;
            head_time     <= '0;
            head_data     <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            underflow     <= 1'b0;
            dropped_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                head_valid <= 1'b1;
                head_time  <= mem_time[rd_ptr[FIFO_ADDR-1:0]];
                head_data  <= mem_data[rd_ptr[FIFO_ADDR-1:0]];
            end else if (fire || drop) begin
                head_valid <= 1'b0;
            end

            out_valid <= fire;
            if (fire) begin
                out_data <= head_data;
            end

            // A drop coinciding with a clear survives as the first new drop.
            if (clear_flags) begin
                underflow     <= drop;
                dropped_count <= {15'd0, drop};
            end else if (drop) begin
                underflow <= 1'b1;
                if (dropped_count != 16'hFFFF) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_timed_event_dispatcher.sv
// Directed bench for timed_event_dispatcher: vector table plus
// hand-written sequences for burst, backpressure, saturation and reset.
module tb_timed_event_dispatcher;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] counter;
    logic        auto_start;
    logic        event_valid;
    logic        event_ready;
    logic [63:0] event_time;
    logic [63:0] event_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic        underflow;
    logic [15:0] dropped_count;
    logic        clear_flags;
    logic        queue_empty;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    timed_event_dispatcher dut (
        .clk(clk),
        .reset(reset),
        .counter(counter),
        .auto_start(auto_start),
        .event_valid(event_valid),
        .event_ready(event_ready),
        .event_time(event_time),
        .event_data(event_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .underflow(underflow),
        .dropped_count(dropped_count),
        .clear_flags(clear_flags),
        .queue_empty(queue_empty)
    );

    typedef struct {
        logic        rst;
        logic        as;
        logic        ev;
        logic        clr;
        logic [63:0] cnt;
        logic [63:0] et;
        logic [63:0] ed;
        logic        ov;
        logic [63:0] od;
        logic        uf;
        logic [15:0] dc;
        logic        qe;
        logic        rdy;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(
        logic rst, logic as, logic ev, logic clr,
        logic [63:0] cnt, logic [63:0] et, logic [63:0] ed,
        logic ov, logic [63:0] od, logic uf, logic [15:0] dc,
        logic qe, logic rdy
    );
        vec_t v;
        v.rst = rst; v.as = as; v.ev = ev; v.clr = clr;
        v.cnt = cnt; v.et = et; v.ed = ed;
        v.ov = ov; v.od = od; v.uf = uf; v.dc = dc;
        v.qe = qe; v.rdy = rdy;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset       = 1'b0;
        event_valid = 1'b0;
        clear_flags = 1'b0;
        event_time  = '0;
        event_data  = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        int idx;
        int nf;
        int acc_n;
        int cyc;
        logic acc;
        logic seen;
        logic [63:0] f_cnt [8];
        logic [63:0] f_dat [8];

        idle_inputs();
        reset      = 1'b1;
        auto_start = 1'b0;
        counter    = '0;

        //         rst as ev clr cnt   et   ed     ov od    uf dc qe rdy
        tbl[0]  = mk(1, 0, 0, 0,   0,   0,    0,   0, 0,    0, 0, 1, 1);
        tbl[1]  = mk(0, 1, 1, 0,   0,  10, 'hAA,  0, 0,    0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 0, 0,   1,   0,    0,   0, 0,    0, 0, 0, 1);
        tbl[3]  = mk(0, 1, 0, 0,   9,   0,    0,   0, 0,    0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 0, 0,  10,   0,    0,   1, 'hAA, 0, 0, 1, 1);
        tbl[5]  = mk(0, 1, 0, 0,  11,   0,    0,   0, 'hAA, 0, 0, 1, 1);
        tbl[6]  = mk(0, 1, 1, 0, 100,  50, 'h55,  0, 'hAA, 0, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 100,   0,    0,   0, 'hAA, 0, 0, 0, 1);
        tbl[8]  = mk(0, 1, 0, 0, 100,   0,    0,   0, 'hAA, 1, 1, 1, 1);
        tbl[9]  = mk(0, 1, 0, 1, 100,   0,    0,   0, 'hAA, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 1, 0, 100,  50, 'h66,  0, 'hAA, 0, 0, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 100,   0,    0,   0, 'hAA, 0, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 1, 100,   0,    0,   0, 'hAA, 1, 1, 1, 1);
        tbl[13] = mk(0, 1, 1, 0, 200, 200, 'h88,  0, 'hAA, 1, 1, 0, 1);
        tbl[14] = mk(0, 1, 0, 0, 201,   0,    0,   0, 'hAA, 1, 1, 0, 1);
        tbl[15] = mk(0, 1, 0, 0, 202,   0,    0,   0, 'hAA, 1, 2, 1, 1);
        tbl[16] = mk(0, 0, 1, 0, 300, 300, 'h77,  0, 'hAA, 1, 2, 0, 1);
        tbl[17] = mk(0, 0, 0, 0, 300,   0,    0,   0, 'hAA, 1, 2, 0, 1);
        tbl[18] = mk(0, 0, 0, 0, 300,   0,    0,   0, 'hAA, 1, 2, 0, 1);
        tbl[19] = mk(0, 1, 0, 0, 300,   0,    0,   1, 'h77, 1, 2, 1, 1);
        tbl[20] = mk(1, 1, 0, 0, 301,   0,    0,   0, 0,    0, 0, 1, 1);

        foreach (tbl[i]) begin
            reset       = tbl[i].rst;
            auto_start  = tbl[i].as;
            event_valid = tbl[i].ev;
            clear_flags = tbl[i].clr;
            counter     = tbl[i].cnt;
            event_time  = tbl[i].et;
            event_data  = tbl[i].ed;
            step();
            chk($sformatf("row%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("row%0d out_data", i), out_data, tbl[i].od);
            chk($sformatf("row%0d underflow", i), 64'(underflow), 64'(tbl[i].uf));
            chk($sformatf("row%0d dropped", i), 64'(dropped_count), 64'(tbl[i].dc));
            chk($sformatf("row%0d queue_empty", i), 64'(queue_empty), 64'(tbl[i].qe));
            chk($sformatf("row%0d ready", i), 64'(event_ready), 64'(tbl[i].rdy));
        end

        // Consecutive timestamps fire on consecutive cycles, in push order.
        do_reset();
        auto_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            counter     = 64'(i);
            event_valid = 1'b1;
            event_time  = 64'(20 + i);
            event_data  = 64'(i + 1);
            step();
        end
        event_valid = 1'b0;
        nf = 0;
        for (int c = 3; c <= 30; c++) begin
            counter = 64'(c);
            step();
            if (out_valid && nf < 8) begin
                f_cnt[nf] = 64'(c);
                f_dat[nf] = out_data;
                nf++;
            end
        end
        chk("burst fire count", 64'(nf), 64'd3);
        for (int i = 0; i < 3 && i < nf; i++) begin
            chk($sformatf("burst%0d counter", i), f_cnt[i], 64'(20 + i));
            chk($sformatf("burst%0d data", i), f_dat[i], 64'(i + 1));
        end

        // Backpressure with dispatch held off, then in-order drain.
        do_reset();
        auto_start = 1'b0;
        counter    = 64'd5;
        idx        = 0;
        for (int i = 0; i < 6; i++) begin
            event_valid = 1'b1;
            event_time  = 64'(1000 + idx);
            event_data  = 64'(idx);
            acc = event_ready;
            step();
            if (acc) idx++;
        end
        event_valid = 1'b0;
        chk("fill accepted", 64'(idx), 64'd5);
        chk("fill ready low", 64'(event_ready), 64'd0);
        auto_start = 1'b1;
        nf = 0;
        for (int c = 1000; c < 1010; c++) begin
            counter = 64'(c);
            step();
            if (out_valid && nf < 8) begin
                f_cnt[nf] = 64'(c);
                f_dat[nf] = out_data;
                nf++;
            end
        end
        chk("drain fire count", 64'(nf), 64'd5);
        for (int i = 0; i < 5 && i < nf; i++) begin
            chk($sformatf("drain%0d counter", i), f_cnt[i], 64'(1000 + i));
            chk($sformatf("drain%0d data", i), f_dat[i], 64'(i));
        end
        chk("drain ready", 64'(event_ready), 64'd1);
        chk("drain empty", 64'(queue_empty), 64'd1);

        // Saturating drop counter.
        do_reset();
        auto_start = 1'b1;
        counter    = 64'd1000;
        event_time = 64'd0;
        acc_n      = 0;
        seen       = 1'b0;
        cyc        = 0;
        while (acc_n < 65538 && cyc < 70000) begin
            event_valid = 1'b1;
            event_data  = 64'(acc_n);
            acc = event_ready;
            step();
            if (acc) acc_n++;
            if (out_valid) seen = 1'b1;
            cyc++;
        end
        event_valid = 1'b0;
        chk("sat accepted", 64'(acc_n), 64'd65538);
        cyc = 0;
        while (!queue_empty && cyc < 20) begin
            step();
            if (out_valid) seen = 1'b1;
            cyc++;
        end
        chk("sat drained", 64'(queue_empty), 64'd1);
        chk("sat dropped", 64'(dropped_count), 64'hFFFF);
        chk("sat underflow", 64'(underflow), 64'd1);
        chk("sat no fire", 64'(seen), 64'd0);

        // Reset discards queued events.
        do_reset();
        auto_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            counter     = 64'(i);
            event_valid = 1'b1;
            event_time  = 64'(50 + i);
            event_data  = 64'(i + 9);
            step();
        end
        event_valid = 1'b0;
        step();
        chk("pre-reset busy", 64'(queue_empty), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("post-reset empty", 64'(queue_empty), 64'd1);
        chk("post-reset ready", 64'(event_ready), 64'd1);
        seen = 1'b0;
        for (int c = 0; c <= 60; c++) begin
            counter = 64'(c);
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("post-reset no fire", 64'(seen), 64'd0);
        chk("post-reset dropped", 64'(dropped_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timed_event_dispatcher.md
TIMED_EVENT_DISPATCHER -- requirements
Module: timed_event_dispatcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, meaning the event payload width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning the event queue depth; power of two, at least 2.
REQ-003 SHALL have parameter FIFO_ADDR, default 2, meaning log2(FIFO_DEPTH).
REQ-004 SHALL have port: clk  in  1  single clock (rtio domain); all logic on its rising edge.
REQ-005 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port: counter  in  64  free-running timestamp from the time controller, already synchronous to clk.
REQ-007 SHALL have port: auto_start  in  1  dispatch enable from the time controller.
REQ-008 SHALL have port: event_valid  in  1  upstream event offered.
REQ-009 SHALL have port: event_ready  out  1  the block accepts the event.
REQ-010 SHALL have port: event_time  in  64  scheduled timestamp of the event.
REQ-011 SHALL have port: event_data  in  DATA_WIDTH  event payload.
REQ-012 SHALL have port: out_valid  out  1  one-cycle pulse marking the event fire.
REQ-013 SHALL have port: out_data  out  DATA_WIDTH  payload of the fired event; held until the next fire.
REQ-014 SHALL have port: underflow  out  1  sticky flag; a late event was dropped.
REQ-015 SHALL have port: dropped_count  out  16  saturating count of dropped events.
REQ-016 SHALL have port: clear_flags  in  1  clears underflow and dropped_count.
REQ-017 SHALL have port: queue_empty  out  1  FIFO and head register both empty.

Function
REQ-018 SHALL store accepted events in a FIFO of FIFO_DEPTH entries {event_time, event_data}, followed by one head register (head_valid, head_time, head_data); total capacity is FIFO_DEPTH+1.
REQ-019 SHALL drive event_ready = !fifo_full, purely from registered state; an event transfers when event_valid && event_ready.
REQ-020 SHALL NOT accept a push while the FIFO is full, even if a pop occurs in the same cycle.
REQ-021 SHALL load the head register from the FIFO in the cycle that head_valid=0 and the FIFO is non-empty; the head becomes valid on the next edge.
REQ-022 SHALL, while head_valid=1 and auto_start=1, compare counter against head_time as unsigned 64-bit values each cycle.
REQ-023 SHALL fire when counter == head_time: on the next edge out_valid=1 for exactly one cycle, out_data=head_data; the head is consumed.
REQ-024 SHALL drop the head when counter > head_time: on the next edge underflow=1; dropped_count increments and saturates at 16'hFFFF; out_valid stays 0; the head is consumed.
REQ-025 SHALL wait with no action when counter < head_time.
REQ-026 SHALL reload the head from the FIFO in the same cycle it is consumed if the FIFO is non-empty, so queued events with consecutive timestamps fire on consecutive cycles.
REQ-027 SHALL suspend comparison while auto_start=0: no fire and no drop; the FIFO still accepts events and the head still loads.
REQ-028 SHALL apply no wrap-around handling to the counter; an event pushed with event_time equal to the current counter value is dropped as late on the first compare cycle.
REQ-029 SHALL clear underflow and zero dropped_count on clear_flags; if a drop occurs in the same cycle, underflow=1 and dropped_count=1.
REQ-030 SHALL dispatch events strictly in acceptance order; no reordering by timestamp.

Reset
REQ-031 SHALL, on reset=1 at a clock edge, empty the FIFO, clear head_valid, and drive out_valid=0, out_data=0, underflow=0, dropped_count=0, queue_empty=1; event_ready=1 in the cycle after.
REQ-032 SHALL discard all queued events when reset is asserted mid-operation; no out_valid pulse occurs in or after the reset cycle.

Verification
REQ-033 SHALL be verified by: auto_start=1, counter ramping from 0, push {time=10, data=0xAA} -> out_valid pulses once, in the cycle after counter==10, with out_data=0xAA.
REQ-034 SHALL be verified by: push times 20, 21, 22 before counter reaches 15 -> three out_valid pulses on consecutive cycles, data in push order.
REQ-035 SHALL be verified by: counter=100, push time=50 -> no out_valid; underflow=1; dropped_count=1. Then pulse clear_flags -> both return to 0.
REQ-036 SHALL be verified by: auto_start=0 while pushing FIFO_DEPTH+2 events -> event_ready falls after FIFO_DEPTH+1 accepts; raising auto_start drains the queue in order.
REQ-037 SHALL be verified by: 0xFFFF+3 late events -> dropped_count holds 16'hFFFF.
REQ-038 SHALL be verified by: reset asserted with 3 events queued -> queue_empty=1; no out_valid pulse afterward, even when counter passes the old timestamps.
